// File: rtl/mux_pkg.sv
// Shared channel constants and round-robin helpers for 4-channel arbitrated blocks.
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [NUM_CH-1:0] ch_mask_t;
    typedef logic [SEL_W-1:0]  ch_sel_t;

    // One-hot grant: first set bit of valid at or after ptr, wrapping 3 -> 0.
    function automatic ch_mask_t rr_pick(input ch_mask_t valid, input ch_sel_t ptr);
        ch_mask_t g;
        ch_sel_t  idx;
        logic     found;
        g     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = ptr + ch_sel_t'(i);
            if (!found && valid[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic ch_sel_t onehot_to_sel(input ch_mask_t oh);
        ch_sel_t s;
        s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) s = s | ch_sel_t'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// Round-robin 4-way arbiter with optional per-channel burst hold.
// Latency: grant is combinational from valid; state updates on the xfer strobe.
// Backpressure: state only advances when the caller reports a transfer.
module rr_arb4
    import mux_pkg::*;
#(
    parameter int BURST_LEN = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  ch_mask_t valid,
    input  logic     xfer,
    output ch_mask_t grant,
    output ch_sel_t  grant_sel
);

    localparam logic [8:0] BURST_MAX = 9'(BURST_LEN);
    localparam logic [7:0] FIRST_CNT = (BURST_LEN > 1) ? 8'd1 : 8'd0;

    ch_sel_t    ptr;
    ch_sel_t    last_grant;
    logic [7:0] burst_cnt;
    logic [8:0] cnt_inc;
    logic       hold;

    assign hold      = (burst_cnt != 8'd0) && valid[last_grant];
    assign cnt_inc   = {1'b0, burst_cnt} + 9'd1;
    assign grant     = hold ? (ch_mask_t'(1) << last_grant) : rr_pick(valid, ptr);
    assign grant_sel = onehot_to_sel(grant);

    // A non-held grant starts a new burst, so ptr already points past the
    // bursting channel and needs no update when the burst later ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            last_grant <= '0;
            burst_cnt  <= '0;
        end else if (xfer) begin
            last_grant <= grant_sel;
            if (hold) begin
                burst_cnt <= (cnt_inc < BURST_MAX) ? cnt_inc[7:0] : 8'd0;
            end else begin
                burst_cnt <= FIRST_CNT;
                ptr       <= grant_sel + 2'd1;
            end
        end else if (burst_cnt != 8'd0 && !valid[last_grant]) begin
            burst_cnt <= '0;
        end
    end

endmodule

// File: rtl/rr_mux_4x1.sv
// 4-to-1 valid/ready merge with round-robin (optionally bursting) arbitration.
// Latency: 1 cycle, registered output, one beat per clock.
// Backpressure: out_ready low holds the output beat and drops all in_ready.
module rr_mux_4x1
    import mux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    logic             load_en;
    logic             xfer;
    ch_mask_t         grant;
    ch_sel_t          grant_sel;
    logic [WIDTH-1:0] grant_dat;

    rr_arb4 #(
        .BURST_LEN (BURST_LEN)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (in_valid),
        .xfer      (xfer),
        .grant     (grant),
        .grant_sel (grant_sel)
    );

    assign load_en   = !out_valid || out_ready;
    // Gated by rst_n so no producer sees ready while the block is held in reset.
    assign in_ready  = (rst_n && load_en) ? grant : '0;
    assign xfer      = |(in_valid & in_ready);
    assign grant_dat = in_data[grant_sel*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_dat;
            out_sel   <= grant_sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
